packet_deparser: RTL and testbench
==================================

// Module: packet_deparser
// PURPOSE
//  Transmit-side counterpart of packet_parser: rebuilds an Ethernet frame on an AXI-Stream master
//  from a metadata word (dst MAC, src MAC, EtherType) and a payload AXI-Stream.
//  Emits the 14-byte header as HDR_BEATS beats, MSB first, then forwards the payload unchanged up to tlast.
//  Sits after the processing stages and before the egress FIFO/MAC.
// PARAMETERS
//  DATA_WIDTH      16   stream tdata width in bits; HDR_WIDTH must be a multiple of it
//  HDR_WIDTH       112  header bits: {dst[47:0], src[47:0], ethertype[15:0]}
//  HDR_BEATS       HDR_WIDTH/DATA_WIDTH (7), derived localparam
//  CNT_WIDTH       32   width of pkt_count
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           asynchronous, active-low reset
//  meta_valid   in   1           metadata word valid
//  meta_ready   out  1           deparser can accept metadata
//  meta_hdr     in   HDR_WIDTH   {dst, src, ethertype}
//  meta_hdr_only in  1           frame has no payload; header beat HDR_BEATS-1 carries tlast
//  s_tdata      in   DATA_WIDTH  payload data
//  s_tvalid     in   1           payload valid
//  s_tlast      in   1           last payload beat
//  s_tready     out  1           payload accepted
//  m_tdata      out  DATA_WIDTH  frame data
//  m_tvalid     out  1           frame valid
//  m_tlast      out  1           last frame beat
//  m_tready     in   1           downstream ready
//  pkt_count    out  CNT_WIDTH   frames fully sent, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  - FSM states: IDLE, HEADER, PAYLOAD. Reset: state=IDLE, beat_cnt=0, hdr_q=0, hdr_only_q=0,
//    meta_ready=0, pkt_count=0. m_tvalid, m_tlast, s_tready, m_tdata are 0 while reset is asserted.
//  - meta_ready is registered: next value is (next_state==IDLE). It is 1 from the first clk after reset release.
//  - IDLE: m_tvalid=0, s_tready=0, m_tdata=0.
//    meta_valid&meta_ready -> latch hdr_q<=meta_hdr, hdr_only_q<=meta_hdr_only, beat_cnt<=0, go HEADER.
//  - HEADER: m_tvalid=1, m_tdata=hdr_q[HDR_WIDTH-1-beat_cnt*DATA_WIDTH -: DATA_WIDTH], s_tready=0.
//    m_tlast = hdr_only_q && beat_cnt==HDR_BEATS-1.
//    On m_tvalid&m_tready: beat_cnt++. At beat_cnt==HDR_BEATS-1: go IDLE if hdr_only_q (pkt_count++), else PAYLOAD.
//    Without m_tready, m_tdata and m_tlast hold stable and m_tvalid stays 1 (AXI rule).
//  - PAYLOAD: combinational pass-through: m_tdata=s_tdata, m_tvalid=s_tvalid, m_tlast=s_tlast, s_tready=m_tready.
//    Handshake with s_tlast=1 -> pkt_count++, go IDLE. A payload without tlast keeps the FSM in PAYLOAD.
//  - Latency: first header beat valid 1 cycle after metadata handshake.
//    After a frame's last beat, one IDLE bubble cycle follows before the next metadata is accepted.
//    Back-to-back frames: last beat at T, meta handshake at T+1, next header beat 0 at T+2.
//  - meta_hdr changes after the handshake do not affect the frame in flight (hdr_q is latched).
//  - Payload beats presented during IDLE/HEADER are not consumed (s_tready=0).
//  - Reset asserted mid-frame aborts at once: outputs go to reset values, and the partial frame is not counted.
// TESTING
//  1 dst=0x001122334455 src=0x66778899AABB type=0x0800, payload 0xDEAD,0xBEEF,0xCAFE(tlast), m_tready=1
//    -> m_tdata 0011,2233,4455,6677,8899,AABB,0800,DEAD,BEEF,CAFE; tlast only on CAFE; pkt_count=1
//  2 same metadata, meta_hdr_only=1 -> 7 beats, tlast on 0x0800, s_tready never 1, pkt_count=1
//  3 test 1 with m_tready toggling every cycle -> identical beat sequence; m_tdata/m_tlast stable while stalled
//  4 change meta_hdr to all-ones during HEADER -> output still 0011..0800; meta_ready=0 throughout HEADER/PAYLOAD
//  5 assert rst after payload beat 0xDEAD -> m_tvalid=0 immediately, pkt_count=0;
//    after release, test 1 frame is sent correctly
//  6 two frames, meta_valid held high -> one m_tvalid=0 bubble between them, second header at T+2, pkt_count=2

Source files
------------

// File: rtl/packet_deparser.sv
`default_nettype none
// ============================================================================
//  Module      : packet_deparser
//  Description : Rebuilds an Ethernet frame on an AXI-Stream master from a
//                latched metadata word {dst, src, ethertype}, emitted MSB
//                first as HDR_BEATS beats, followed by the payload stream
//                forwarded unchanged up to and including tlast.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_deparser #(
   parameter int DATA_WIDTH = 16,
   parameter int HDR_WIDTH  = 112,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,            // asynchronous, active-low
   input  logic                  meta_valid,
   output logic                  meta_ready,
   input  logic [HDR_WIDTH-1:0]  meta_hdr,
   input  logic                  meta_hdr_only,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   output logic [CNT_WIDTH-1:0]  pkt_count
);

   localparam int HDR_BEATS = HDR_WIDTH / DATA_WIDTH;
   localparam int BEAT_W    = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
   localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(HDR_BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   state_t                  r_state;
   logic [BEAT_W-1:0]       r_beat_cnt;
   logic [HDR_WIDTH-1:0]    r_hdr_q;
   logic                    r_hdr_only_q;
   logic                    r_meta_ready;
   logic [CNT_WIDTH-1:0]    r_pkt_count;

   logic [DATA_WIDTH-1:0]   w_hdr_beat [HDR_BEATS];
   logic                    w_hdr_last_beat;

   // Split the latched header into beats, beat 0 being the most significant slice
   for (genvar g = 0; g < HDR_BEATS; g++) begin : g_hdr_beat
      assign w_hdr_beat[g] = r_hdr_q[HDR_WIDTH-1-g*DATA_WIDTH -: DATA_WIDTH];
   end

   assign w_hdr_last_beat = (r_beat_cnt == c_last_beat);
   assign meta_ready      = r_meta_ready;
   assign pkt_count       = r_pkt_count;

   // Frame sequencer: metadata latch, header beat counter, frame counter and
   // meta_ready, which is 1 exactly when the next state is IDLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_beat_cnt   <= '0;
         r_hdr_q      <= '0;
         r_hdr_only_q <= 1'b0;
         r_meta_ready <= 1'b0;
         r_pkt_count  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (meta_valid && r_meta_ready) begin
                  r_hdr_q      <= meta_hdr;
                  r_hdr_only_q <= meta_hdr_only;
                  r_beat_cnt   <= '0;
                  r_state      <= ST_HEADER;
                  r_meta_ready <= 1'b0;
               end else begin
                  r_meta_ready <= 1'b1;
               end
            end
            ST_HEADER: begin
               r_meta_ready <= 1'b0;
               if (m_tready) begin
                  if (w_hdr_last_beat) begin
                     r_beat_cnt <= '0;
                     if (r_hdr_only_q) begin
                        r_state      <= ST_IDLE;
                        r_meta_ready <= 1'b1;
                        r_pkt_count  <= r_pkt_count + CNT_WIDTH'(1);
                     end else begin
                        r_state <= ST_PAYLOAD;
                     end
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                  end
               end
            end
            ST_PAYLOAD: begin
               r_meta_ready <= 1'b0;
               if (s_tvalid && m_tready && s_tlast) begin
                  r_state      <= ST_IDLE;
                  r_meta_ready <= 1'b1;
                  r_pkt_count  <= r_pkt_count + CNT_WIDTH'(1);
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_meta_ready <= 1'b1;
            end
         endcase
      end
   end

   // Output steering: header beats from the latch, payload as a pure pass-through
   always_comb begin
      m_tdata  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      s_tready = 1'b0;
      case (r_state)
         ST_HEADER: begin
            m_tvalid = 1'b1;
            m_tdata  = w_hdr_beat[r_beat_cnt];
            m_tlast  = r_hdr_only_q && w_hdr_last_beat;
         end
         ST_PAYLOAD: begin
            m_tvalid = s_tvalid;
            m_tdata  = s_tdata;
            m_tlast  = s_tlast;
            s_tready = m_tready;
         end
         default: begin
            m_tvalid = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_packet_deparser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_deparser
//  Description : Self-checking bench for packet_deparser. A frame-level model
//                predicts the output beat sequence, frame count and
//                handshake behaviour; stimulus is directed plus randomized.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_deparser;

   localparam int DW = 16;
   localparam int HW = 112;
   localparam int CW = 32;
   localparam int NB = HW / DW;
   localparam logic [HW-1:0] c_h1 = 112'h001122334455_66778899AABB_0800;

   logic          clk = 1'b0;
   logic          rst;
   logic          meta_valid, meta_ready, meta_hdr_only;
   logic [HW-1:0] meta_hdr;
   logic [DW-1:0] s_tdata, m_tdata;
   logic          s_tvalid, s_tlast, s_tready;
   logic          m_tvalid, m_tlast, m_tready;
   logic [CW-1:0] pkt_count;

   packet_deparser #(.DATA_WIDTH(DW), .HDR_WIDTH(HW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .meta_valid(meta_valid), .meta_ready(meta_ready),
      .meta_hdr(meta_hdr), .meta_hdr_only(meta_hdr_only),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Frame table and expected-beat scoreboard
   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
      logic          first;
   } beat_t;

   beat_t         exp_q[$];
   logic [HW-1:0] f_hdr  [32];
   logic          f_only [32];
   int            f_len  [32];
   logic [DW-1:0] f_pay  [32][8];

   // Test controls
   int rdy_mode     = 0;   // 0: always ready, 1: toggle, 2: random
   bit rand_dly     = 1'b0;
   bit garble       = 1'b0;
   bit no_sready    = 1'b0;
   bit gap_chk      = 1'b0;

   // Monitor state
   int unsigned model_cnt = 0;
   bit   in_flight = 1'b0, just_hs = 1'b0, have_last = 1'b0;
   bit   prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
   logic [DW-1:0] prev_d = '0;
   int   cyc = 0, last_cyc = 0, rst_cycles = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk or negedge rst)
      if (!rst) rst_cycles <= 0;
      else      rst_cycles <= rst_cycles + 1;

   // Output monitor: compares every handshake with the scoreboard and checks
   // the handshake-level rules (stall stability, meta_ready, latency, gaps)
   always @(negedge clk) begin
      if (!rst) begin
         in_flight = 1'b0; just_hs = 1'b0; have_last = 1'b0;
         prev_v = 1'b0; model_cnt = 0;
      end else begin
         check_eq("pkt_count", pkt_count, model_cnt);
         if (rst_cycles >= 1) check_eq("meta_ready", meta_ready, !in_flight);
         if (just_hs) begin
            check_eq("hdr_latency_valid", m_tvalid, 1'b1);
            if (exp_q.size() != 0) check_eq("hdr_latency_data", m_tdata, exp_q[0].d);
         end
         if (prev_v && !prev_r) begin
            check_eq("stall_valid", m_tvalid, 1'b1);
            check_eq("stall_data", m_tdata, prev_d);
            check_eq("stall_last", m_tlast, prev_l);
         end
         if (no_sready) check_eq("s_tready_hdr_only", s_tready, 1'b0);
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_beat", m_tdata, 'x);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check_eq("beat_data", m_tdata, e.d);
               check_eq("beat_last", m_tlast, e.l);
               if (e.first && gap_chk && have_last) check_eq("b2b_gap", cyc - last_cyc, 2);
               if (e.l) begin
                  model_cnt++;
                  in_flight = 1'b0;
                  last_cyc  = cyc;
                  have_last = 1'b1;
               end
            end
         end
         just_hs = meta_valid && meta_ready;
         if (just_hs) in_flight = 1'b1;
         prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata; prev_l = m_tlast;
      end
   end

   // Downstream ready generator
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_frame(input int i, input logic [HW-1:0] h, input logic only, input int len,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
      f_hdr[i] = h; f_only[i] = only; f_len[i] = len;
      f_pay[i][0] = d0; f_pay[i][1] = d1; f_pay[i][2] = d2;
   endtask

   // Reference frame: header words taken from the top down, then the payload
   task automatic push_expected(input int i);
      beat_t e;
      for (int b = 0; b < NB; b++) begin
         e.d     = DW'(f_hdr[i] >> (DW * (NB - 1 - b)));
         e.l     = f_only[i] && (b == NB - 1);
         e.first = (b == 0);
         exp_q.push_back(e);
      end
      if (!f_only[i]) begin
         for (int p = 0; p < f_len[i]; p++) begin
            e.d = f_pay[i][p]; e.l = (p == f_len[i] - 1); e.first = 1'b0;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic send_meta(input int i);
      int k;
      if (rand_dly) repeat ($urandom_range(0, 3)) tick();
      meta_hdr = f_hdr[i]; meta_hdr_only = f_only[i]; meta_valid = 1'b1;
      push_expected(i);
      for (k = 0; k < 500; k++) begin
         @(negedge clk);
         if (meta_ready) break;
      end
      if (k == 500) check_eq("meta_timeout", 1'b1, 1'b0);
      tick();
      meta_valid = 1'b0;
      if (garble) meta_hdr = '1;
   endtask

   task automatic send_payload(input int i);
      int k;
      for (int p = 0; p < f_len[i]; p++) begin
         if (rand_dly) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         s_tdata = f_pay[i][p]; s_tlast = (p == f_len[i] - 1); s_tvalid = 1'b1;
         for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (s_tready) break;
         end
         if (k == 500) check_eq("payload_timeout", 1'b1, 1'b0);
         tick();
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic run_frames(input int base, input int n);
      int k;
      fork
         begin
            for (int i = base; i < base + n; i++) send_meta(i);
         end
         begin
            for (int i = base; i < base + n; i++) if (!f_only[i]) send_payload(i);
         end
      join
      for (k = 0; k < 400 && exp_q.size() != 0; k++) tick();
      check_eq("drain", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      meta_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
      repeat (2) tick();
      exp_q.delete();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      int k;
      logic [127:0] rnd;
      rst = 1'b0;
      meta_valid = 1'b0; meta_hdr = '0; meta_hdr_only = 1'b0;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      // Reset state
      check_eq("rst_m_tvalid", m_tvalid, 1'b0);
      check_eq("rst_m_tlast", m_tlast, 1'b0);
      check_eq("rst_m_tdata", m_tdata, '0);
      check_eq("rst_s_tready", s_tready, 1'b0);
      check_eq("rst_meta_ready", meta_ready, 1'b0);
      check_eq("rst_pkt_count", pkt_count, '0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      check_eq("meta_ready_after_rst", meta_ready, 1'b1);

      // Basic frame
      set_frame(0, c_h1, 1'b0, 3, 16'hDEAD, 16'hBEEF, 16'hCAFE);
      set_frame(1, c_h1, 1'b1, 0, '0, '0, '0);
      run_frames(0, 1);
      check_eq("t1_pkt_count", pkt_count, 1);

      // Header-only frame
      do_reset();
      no_sready = 1'b1;
      run_frames(1, 1);
      no_sready = 1'b0;
      check_eq("t2_pkt_count", pkt_count, 1);

      // Downstream stalls every other cycle
      do_reset();
      rdy_mode = 1;
      run_frames(0, 1);
      rdy_mode = 0;
      check_eq("t3_pkt_count", pkt_count, 1);

      // Metadata changed after it was accepted
      garble = 1'b1;
      run_frames(0, 1);
      garble = 1'b0;
      check_eq("t4_pkt_count", pkt_count, 2);

      // Reset in the middle of the payload
      do_reset();
      send_meta(0);
      s_tdata = 16'hDEAD; s_tlast = 1'b0; s_tvalid = 1'b1;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (s_tready) break;
      end
      check_eq("t5_dead_accepted", s_tready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check_eq("t5_m_tvalid", m_tvalid, 1'b0);
      check_eq("t5_s_tready", s_tready, 1'b0);
      check_eq("t5_pkt_count", pkt_count, '0);
      s_tvalid = 1'b0;
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b1;
      tick();
      run_frames(0, 1);
      check_eq("t5_after_pkt_count", pkt_count, 1);

      // Back-to-back frames with metadata held valid
      do_reset();
      set_frame(2, c_h1, 1'b0, 3, 16'hDEAD, 16'hBEEF, 16'hCAFE);
      gap_chk = 1'b1;
      run_frames(0, 1 + 1);
      gap_chk = 1'b0;
      check_eq("t6_pkt_count", pkt_count, 2);

      // Randomized frames with random stalls and gaps
      do_reset();
      rdy_mode = 2;
      rand_dly = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         f_hdr[i]  = rnd[HW-1:0];
         f_only[i] = ($urandom_range(0, 3) == 0);
         f_len[i]  = $urandom_range(1, 8);
         for (int p = 0; p < 8; p++) f_pay[i][p] = DW'($urandom);
      end
      run_frames(0, 20);
      check_eq("rand_pkt_count", pkt_count, 20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
